// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the MIPS-lite 5-stage pipeline: load-use stall, branch flush,
// EX forwarding selects, WB->ID bypass and HALT drain, driven by a shadow EX/MEM/WB scoreboard.
module pipeline_hazard_ctrl #(
  parameter int unsigned REGISTER_WIDTH = 5,
  parameter int unsigned OPCODE_WIDTH   = 6,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [OPCODE_WIDTH-1:0]   id_opcode,
  input  logic [REGISTER_WIDTH-1:0] id_rs,
  input  logic [REGISTER_WIDTH-1:0] id_rt,
  input  logic                      id_rs_used,
  input  logic                      id_rt_used,
  input  logic [REGISTER_WIDTH-1:0] id_dest,
  input  logic                      id_reg_write,
  input  logic                      ex_branch_taken,
  output logic                      stall,
  output logic                      flush,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic                      bypass_a,
  output logic                      bypass_b,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam logic [OPCODE_WIDTH-1:0] OpLoad = OPCODE_WIDTH'(6'h0C);
  localparam logic [OPCODE_WIDTH-1:0] OpHalt = OPCODE_WIDTH'(6'h11);
  localparam logic [1:0] FwdNone = 2'b00;
  localparam logic [1:0] FwdMem  = 2'b01;
  localparam logic [1:0] FwdWb   = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic [REGISTER_WIDTH-1:0] dest;
    logic                      reg_write;
    logic                      is_load;
  } entry_t;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  entry_t ex_q, mem_q, wb_q, ex_d;
  state_e state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       halted_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  function automatic logic reg_match(input entry_t e, input logic [REGISTER_WIDTH-1:0] src,
                                     input logic used);
    return used && e.valid && e.reg_write && (e.dest != '0) && (e.dest == src);
  endfunction

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic load_use, enter;

  assign ex_hit_a  = reg_match(ex_q, id_rs, id_rs_used);
  assign ex_hit_b  = reg_match(ex_q, id_rt, id_rt_used);
  assign mem_hit_a = reg_match(mem_q, id_rs, id_rs_used);
  assign mem_hit_b = reg_match(mem_q, id_rt, id_rt_used);
  assign wb_hit_a  = reg_match(wb_q, id_rs, id_rs_used);
  assign wb_hit_b  = reg_match(wb_q, id_rt, id_rt_used);
  assign load_use  = id_valid && ex_q.is_load && (ex_hit_a || ex_hit_b);

  always_comb begin
    stall       = 1'b0;
    flush       = 1'b0;
    bypass_a    = 1'b0;
    bypass_b    = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (reset) begin
      bypass_a = wb_hit_a;
      bypass_b = wb_hit_b;
      unique case (state_q)
        StRun: begin
          // A taken branch squashes the ID instruction, so it overrides any load-use stall.
          flush = ex_branch_taken;
          stall = load_use && !ex_branch_taken;
          if (id_valid && (id_opcode == OpHalt) && !flush && !stall) begin
            state_d     = StDrain;
            drain_cnt_d = 2'd0;
          end
        end
        StDrain: begin
          stall       = 1'b1;
          drain_cnt_d = drain_cnt_q + 2'd1;
          if (drain_cnt_q == 2'd2) state_d = StHalted;
        end
        StHalted: stall = 1'b1;
        default:  state_d = StRun;
      endcase
    end
  end

  assign enter = (state_q == StRun) && id_valid && !stall && !flush && (id_opcode != OpHalt);

  always_comb begin
    ex_d    = '0;
    fwd_a_d = FwdNone;
    fwd_b_d = FwdNone;
    if (enter) begin
      ex_d.valid     = 1'b1;
      ex_d.dest      = id_dest;
      ex_d.reg_write = id_reg_write;
      ex_d.is_load   = (id_opcode == OpLoad);
      // EX holds the youngest producer, so it is checked before MEM.
      fwd_a_d = ex_hit_a ? FwdMem : (mem_hit_a ? FwdWb : FwdNone);
      fwd_b_d = ex_hit_b ? FwdMem : (mem_hit_b ? FwdWb : FwdNone);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= StRun;
      drain_cnt_q <= 2'd0;
      fwd_a_q     <= FwdNone;
      fwd_b_q     <= FwdNone;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      halted_q    <= (state_q == StHalted);
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;
  assign halted       = halted_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared against an in-flight-instruction reference model.
module tb_pipeline_hazard_ctrl;

  localparam int SAT = 65535;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_rs_used = 1'b0, id_rt_used = 1'b0, id_reg_write = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       stall, flush, bypass_a, bypass_b, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .id_dest         (id_dest),
    .id_reg_write    (id_reg_write),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush           (flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .bypass_a        (bypass_a),
    .bypass_b        (bypass_b),
    .halted          (halted),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  // Reference model: instructions in flight by age (0 = EX, 1 = MEM, 2 = WB).
  typedef struct { bit v; int dest; bit rw; bit ld; } ent_t;
  ent_t pipe [3];
  bit   m_halt;
  int   m_age, m_scnt, m_fcnt, m_fa, m_fb;
  bit   e_stall, e_flush, e_bpa, e_bpb;
  int   checks = 0;
  int   errors = 0;

  function automatic bit hit(ent_t e, int src, bit used);
    return used && e.v && e.rw && (e.dest != 0) && (e.dest == src);
  endfunction

  function automatic int producer(int src, bit used);
    for (int age = 0; age < 2; age++) if (hit(pipe[age], src, used)) return age + 1;
    return 0;
  endfunction

  function automatic bit m_halted();
    return m_halt && (m_age >= 4);
  endfunction

  function automatic void model_comb();
    e_stall = 0; e_flush = 0; e_bpa = 0; e_bpb = 0;
    if (reset) begin
      e_bpa = hit(pipe[2], int'(id_rs), id_rs_used);
      e_bpb = hit(pipe[2], int'(id_rt), id_rt_used);
      if (m_halt) e_stall = 1;
      else begin
        e_flush = ex_branch_taken;
        e_stall = !ex_branch_taken && id_valid && pipe[0].ld &&
                  (hit(pipe[0], int'(id_rs), id_rs_used) || hit(pipe[0], int'(id_rt), id_rt_used));
      end
    end
  endfunction

  function automatic void model_edge();
    bit enters;
    if (!reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
      m_halt = 0; m_age = 0; m_scnt = 0; m_fcnt = 0; m_fa = 0; m_fb = 0;
      return;
    end
    if (e_stall && m_scnt < SAT) m_scnt++;
    if (e_flush && m_fcnt < SAT) m_fcnt++;
    enters = !m_halt && id_valid && !e_stall && !e_flush && (id_opcode != 6'h11);
    m_fa = enters ? producer(int'(id_rs), id_rs_used) : 0;
    m_fb = enters ? producer(int'(id_rt), id_rt_used) : 0;
    if (m_halt) m_age++;
    else if (id_valid && id_opcode == 6'h11 && !e_stall && !e_flush) begin
      m_halt = 1; m_age = 0;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = enters ? '{1, int'(id_dest), id_reg_write, id_opcode == 6'h0C} : '{0, 0, 0, 0};
  endfunction

  task automatic apply(bit v, logic [5:0] op, int rs, bit rsu, int rt, bit rtu, int dest,
                       bit rw, bit br);
    id_valid = v; id_opcode = op; id_rs = 5'(rs); id_rs_used = rsu; id_rt = 5'(rt);
    id_rt_used = rtu; id_dest = 5'(dest); id_reg_write = rw; ex_branch_taken = br;
    #1;
    model_comb();
  endtask

  task automatic idle();
    apply(0, 6'h00, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    apply(1, 6'h0C, 3, 1, 3, 1, 3, 1, 1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    tick();
    tick();
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL reset_fwd got %b/%b exp 00/00", fwd_a, fwd_b); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cycles, flush_count); end
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    apply(1, 6'h0C, 1, 1, 0, 0, 3, 1, 0);  // ldw r3
    tick();
    apply(1, 6'h00, 3, 1, 5, 1, 4, 1, 0);  // add r4,r3,r5
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got %b exp 0", stall); end
    checks++; if (stall_cycles !== 16'd1) begin
      errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cycles); end
    tick();
    checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL lu_fwd got %b/%b exp 10/00", fwd_a, fwd_b); end
    checks++; if (stall_cycles !== 16'd1) begin
      errors++; $display("FAIL lu_cnt2 got %0d exp 1", stall_cycles); end
  endtask

  task automatic test_forwarding();
    logic [1:0] exp_fwd [3];
    bit         exp_bp [3];
    exp_fwd = '{2'b01, 2'b10, 2'b00};
    exp_bp  = '{1'b0, 1'b0, 1'b1};
    for (int d = 0; d < 3; d++) begin
      do_reset();
      apply(1, 6'h00, 1, 1, 1, 1, 2, 1, 0);  // add r2,r1,r1
      tick();
      for (int k = 0; k < d; k++) begin idle(); tick(); end
      apply(1, 6'h22, 2, 1, 2, 1, 6, 1, 0);  // sub r6,r2,r2
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd%0d_stall got %b exp 0", d, stall); end
      checks++; if (bypass_a !== exp_bp[d] || bypass_b !== exp_bp[d]) begin
        errors++; $display("FAIL fwd%0d_bypass got %b/%b exp %b", d, bypass_a, bypass_b, exp_bp[d]); end
      tick();
      checks++; if (fwd_a !== exp_fwd[d] || fwd_b !== exp_fwd[d]) begin
        errors++; $display("FAIL fwd%0d_sel got %b/%b exp %b", d, fwd_a, fwd_b, exp_fwd[d]); end
    end
  endtask

  task automatic test_r0();
    do_reset();
    apply(1, 6'h0C, 1, 1, 0, 0, 0, 1, 0);  // ldw r0
    tick();
    apply(1, 6'h00, 0, 1, 0, 1, 4, 1, 0);  // reader of r0
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %b exp 0", stall); end
    tick();
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL r0_fwd got %b/%b exp 00/00", fwd_a, fwd_b); end
    apply(1, 6'h00, 0, 1, 0, 1, 5, 1, 0);
    tick();
    checks++; if (bypass_a !== 1'b0 || bypass_b !== 1'b0) begin
      errors++; $display("FAIL r0_bypass got %b/%b exp 0/0", bypass_a, bypass_b); end
  endtask

  task automatic test_flush_priority();
    do_reset();
    apply(1, 6'h0C, 1, 1, 0, 0, 3, 1, 0);  // ldw r3
    tick();
    apply(1, 6'h00, 3, 1, 5, 1, 4, 1, 1);  // add r4,r3,r5 with branch taken
    checks++; if (flush !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL fl_prio got flush %b stall %b exp 1/0", flush, stall); end
    tick();
    checks++; if (flush_count !== 16'd1 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL fl_cnt got %0d/%0d exp 1/0", flush_count, stall_cycles); end
    apply(1, 6'h00, 4, 1, 4, 1, 7, 1, 0);  // reader of the squashed add's r4
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall2 got %b exp 0", stall); end
    tick();
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++; $display("FAIL fl_squash got %b/%b exp 00/00", fwd_a, fwd_b); end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 1; i <= 3; i++) begin apply(1, 6'h00, 0, 0, 0, 0, i, 1, 0); tick(); end
    apply(1, 6'h11, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL halt_id_stall got %b exp 0", stall); end
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_e0 got %b exp 0", halted); end
    for (int i = 1; i <= 6; i++) begin
      apply(1, 6'h0C, 3, 1, 3, 1, 3, 1, i[0]);
      checks++; if (stall !== 1'b1 || flush !== 1'b0) begin
        errors++; $display("FAIL halt_seq%0d got stall %b flush %b exp 1/0", i, stall, flush); end
      tick();
      checks++; if (halted !== (i >= 4)) begin
        errors++; $display("FAIL halt_edge%0d got %b exp %b", i, halted, i >= 4); end
    end
    checks++; if (stall_cycles !== 16'd6 || flush_count !== 16'd0) begin
      errors++; $display("FAIL halt_cnt got %0d/%0d exp 6/0", stall_cycles, flush_count); end
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL halt_rst_comb got %b/%b exp 0/0", stall, flush); end
    tick();
    reset = 1'b1;
    apply(1, 6'h00, 1, 1, 2, 1, 3, 1, 0);
    checks++; if (halted !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL halt_rst got halted %b stall %b exp 0/0", halted, stall); end
    checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL halt_rst_cnt got %0d/%0d exp 0/0", stall_cycles, flush_count); end
    // Reset in the middle of DRAIN.
    apply(1, 6'h11, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    apply(1, 6'h00, 1, 1, 2, 1, 3, 1, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drain_rst_stall got %b exp 0", stall); end
  endtask

  task automatic test_random();
    bit ld;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ld = ($urandom_range(2) == 0);
      apply($urandom_range(7) != 0, ld ? 6'h0C : 6'h00, $urandom_range(3), 1'($urandom),
            $urandom_range(3), 1'($urandom), $urandom_range(3), $urandom_range(4) != 0,
            $urandom_range(7) == 0);
      checks++; if (stall !== e_stall || flush !== e_flush) begin
        errors++; $display("FAIL rnd_ctl c%0d got %b/%b exp %b/%b", c, stall, flush, e_stall, e_flush); end
      checks++; if (bypass_a !== e_bpa || bypass_b !== e_bpb) begin
        errors++; $display("FAIL rnd_bp c%0d got %b/%b exp %b/%b", c, bypass_a, bypass_b, e_bpa, e_bpb); end
      tick();
      checks++; if (fwd_a !== 2'(m_fa) || fwd_b !== 2'(m_fb)) begin
        errors++; $display("FAIL rnd_fwd c%0d got %b/%b exp %0d/%0d", c, fwd_a, fwd_b, m_fa, m_fb); end
      checks++; if (stall_cycles !== 16'(m_scnt) || flush_count !== 16'(m_fcnt)) begin
        errors++; $display("FAIL rnd_cnt c%0d got %0d/%0d exp %0d/%0d", c, stall_cycles, flush_count,
                           m_scnt, m_fcnt); end
      checks++; if (halted !== m_halted()) begin
        errors++; $display("FAIL rnd_halted c%0d got %b exp %b", c, halted, m_halted()); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    apply(1, 6'h11, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    repeat (70000) tick();
    checks++; if (stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat got %h exp ffff", stall_cycles); end
    checks++; if (halted !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL sat_halted got %b/%b exp 1/1", halted, stall); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_r0();
    test_flush_priority();
    test_halt();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
